// File: rtl/oddr_serializer.sv
// Multi-lane DDR output serializer: parallel words in through a one-word skid buffer,
// two bits per lane per clock out to per-lane ODDR models, with idle, training and underrun handling.

module oddr_wrap #(
  parameter logic INIT = 1'b1
) (
  input  logic c,
  input  logic reset,
  input  logic d_rise,
  input  logic d_fall,
  output logic o
);
  logic rise_q, fall_q;

  always_ff @(posedge c) begin
    if (reset) begin
      rise_q <= INIT;
      fall_q <= INIT;
    end else begin
      rise_q <= d_rise;
      fall_q <= d_fall;
    end
  end

  // behavioural pad mux: rising bit while c is high, falling bit while low
  assign o = c ? rise_q : fall_q;
endmodule

module oddr_serializer #(
  parameter int             LANES  = 4,
  parameter int             WORD   = 8,
  parameter logic [LANES-1:0] INVERT = '0,
  parameter logic           IDLE   = 1'b1
) (
  input  logic                   c,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [WORD-1:0]        train_pattern,
  input  logic [LANES*WORD-1:0]  din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic                   underrun,
  output logic [7:0]             underrun_count,
  output logic [2*LANES-1:0]     q_pair,
  output logic [LANES-1:0]       o
);
  localparam int SLOTS = WORD / 2;
  localparam int BW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  if (WORD < 2 || WORD > 32 || (WORD % 2) != 0) begin : g_bad_word
    $error("oddr_serializer: WORD must be even and within 2..32");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("oddr_serializer: LANES must be within 1..16");
  end

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TRAIN} state_t;

  state_t                       state_q, state_d;
  logic [BW-1:0]                beat_q;
  logic                         hold_full_q;
  logic [LANES-1:0][WORD-1:0]   hold_q, shift_q, shift_d, next_word, src;
  logic [LANES-1:0][1:0]        pair_q, pair_d;
  logic                         underrun_q;
  logic [7:0]                   count_q;
  logic                         boundary, accept, load_hold, starve;

  function automatic logic [WORD-1:0] shr2(input logic [WORD-1:0] w);
    logic [WORD+1:0] e;
    e = {{2{IDLE}}, w};
    return e[WORD+1:2];
  endfunction

  assign boundary  = (beat_q == BW'(SLOTS - 1));
  assign din_ready = !hold_full_q && !reset;
  assign accept    = din_valid && din_ready;

  // the mode sampled at a boundary selects what that boundary loads, so a
  // mid-word mode change completes the current word and acts at the next boundary
  always_comb begin
    state_d = state_q;
    if (boundary) begin
      case (mode)
        2'd1:    state_d = S_DATA;
        2'd2:    state_d = S_TRAIN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign load_hold = boundary && (state_d == S_DATA) && hold_full_q;
  assign starve    = boundary && (state_d == S_DATA) && !hold_full_q;

  always_comb begin
    next_word = {LANES*WORD{IDLE}};
    if (state_d == S_TRAIN) begin
      for (int n = 0; n < LANES; n++) next_word[n] = train_pattern;
    end else if (load_hold) begin
      next_word = hold_q;
    end
    for (int n = 0; n < LANES; n++) begin
      // first pair of a new word goes straight to q_pair; the rest waits in the shifter
      src[n]     = boundary ? next_word[n] : shift_q[n];
      pair_d[n]  = src[n][1:0] ^ {2{INVERT[n]}};
      shift_d[n] = shr2(src[n]);
    end
  end

  always_ff @(posedge c) begin
    if (reset) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shift_q     <= {LANES*WORD{IDLE}};
      for (int n = 0; n < LANES; n++) pair_q[n] <= {2{IDLE ^ INVERT[n]}};
      underrun_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= boundary ? '0 : beat_q + BW'(1);
      shift_q    <= shift_d;
      pair_q     <= pair_d;
      underrun_q <= starve;
      if (starve && count_q != 8'hFF) count_q <= count_q + 8'd1;
      if (accept) begin
        hold_full_q <= 1'b1;
        hold_q      <= din;
      end else if (load_hold) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign underrun       = underrun_q;
  assign underrun_count = count_q;
  assign q_pair         = pair_q;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    oddr_wrap #(.INIT(IDLE ^ INVERT[n])) u_oddr (
      .c      (c),
      .reset  (reset),
      .d_rise (pair_q[n][0]),
      .d_fall (pair_q[n][1]),
      .o      (o[n])
    );
  end
endmodule

// File: tb/tb_oddr_serializer.sv
// Directed bench for oddr_serializer: LANES=4, WORD=8, lane 1 inverted, idle level 1.

module tb_oddr_serializer;
  localparam int         LANES = 4;
  localparam int         WORD  = 8;
  localparam logic [3:0] INV   = 4'b0010;

  logic        c = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [7:0]  train_pattern;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        underrun;
  logic [7:0]  underrun_count;
  logic [7:0]  q_pair;
  logic [3:0]  o;

  int total = 0;
  int bad   = 0;
  int bbeat = 0;

  logic [31:0] words [0:5];

  oddr_serializer #(.LANES(LANES), .WORD(WORD), .INVERT(INV), .IDLE(1'b1)) dut (
    .c(c), .reset(reset), .mode(mode), .train_pattern(train_pattern),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .underrun(underrun), .underrun_count(underrun_count),
    .q_pair(q_pair), .o(o)
  );

  always #5 c = ~c;

  // bench-side beat tracker: 0 after reset, wraps every 4 clocks
  task automatic tick();
    logic r;
    r = reset;
    @(posedge c);
    #1;
    bbeat = r ? 0 : (bbeat + 1) % 4;
  endtask

  function automatic logic [7:0] exp_pair(input logic [31:0] w, input int k);
    logic [7:0] r;
    for (int n = 0; n < 4; n++) r[2*n +: 2] = w[n*8 + 2*k +: 2] ^ {2{INV[n]}};
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; mode = 2'd0; train_pattern = 8'h00; din = '0; din_valid = 1'b0;
    tick(); tick();
    total++; if (q_pair !== 8'hF3) begin bad++; $display("FAIL reset_qpair got=%h want=%h", q_pair, 8'hF3); end
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", din_ready); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
    total++; if (underrun_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", underrun_count); end
    reset = 1'b0;
    #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b want=1", din_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (q_pair !== 8'hF3) begin bad++; $display("FAIL idle_qpair cyc=%0d got=%h want=%h", i, q_pair, 8'hF3); end
      total++; if (o !== 4'b1101) begin bad++; $display("FAIL idle_o cyc=%0d got=%b want=1101", i, o); end
    end
  endtask

  task automatic test_stream();
    logic [7:0] w0tab [4];
    logic [7:0] e;
    int widx;
    bit acc;
    w0tab = '{8'h3D, 8'h31, 8'hC2, 8'hCE};
    while (bbeat != 2) tick();
    din = words[0]; din_valid = 1'b1; mode = 2'd1; widx = 0;
    for (int s = 0; s < 13; s++) begin
      acc = din_valid && din_ready;
      tick();
      if (acc) begin
        widx++;
        if (widx < 3) din = words[widx]; else din_valid = 1'b0;
      end
      if (s >= 1) begin
        e = ((s - 1) / 4 == 0) ? w0tab[(s - 1) % 4] : exp_pair(words[(s - 1) / 4], (s - 1) % 4);
        total++; if (q_pair !== e) begin bad++; $display("FAIL stream_qpair step=%0d got=%h want=%h", s, q_pair, e); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL stream_underrun step=%0d got=%b want=0", s, underrun); end
      end
      if (s == 2) begin
        total++; if (o !== 4'b0111) begin bad++; $display("FAIL oddr_rise got=%b want=0111", o); end
        @(negedge c); #1;
        total++; if (o !== 4'b0110) begin bad++; $display("FAIL oddr_fall got=%b want=0110", o); end
      end
    end
    total++; if (widx !== 3) begin bad++; $display("FAIL stream_accepts got=%0d want=3", widx); end
  endtask

  task automatic test_underrun();
    int pulses;
    tick();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_pulse got=%b want=1", underrun); end
    total++; if (underrun_count !== 8'd1) begin bad++; $display("FAIL underrun_count1 got=%0d want=1", underrun_count); end
    total++; if (q_pair !== 8'hF3) begin bad++; $display("FAIL underrun_idle got=%h want=%h", q_pair, 8'hF3); end
    tick();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_width got=%b want=0", underrun); end
    pulses = 0;
    repeat (1200) begin
      tick();
      if (underrun === 1'b1) pulses++;
    end
    total++; if (pulses !== 300) begin bad++; $display("FAIL underrun_pulses got=%0d want=300", pulses); end
    total++; if (underrun_count !== 8'd255) begin bad++; $display("FAIL underrun_sat got=%0d want=255", underrun_count); end
  endtask

  task automatic test_train();
    logic [7:0] tr [4];
    tr = '{8'hA6, 8'hA6, 8'hA6, 8'h59};
    mode = 2'd2; train_pattern = 8'h6A; din = words[3]; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    while (bbeat != 3) tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (q_pair !== tr[i % 4]) begin bad++; $display("FAIL train_qpair cyc=%0d got=%h want=%h", i, q_pair, tr[i % 4]); end
      total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL train_hold cyc=%0d got=%b want=0", i, din_ready); end
    end
    mode = 2'd1;
    tick();
    total++; if (q_pair !== 8'h5B) begin bad++; $display("FAIL train_release got=%h want=%h", q_pair, 8'h5B); end
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL train_release_ready got=%b want=1", din_ready); end
  endtask

  task automatic test_mode_switch();
    din = words[4]; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    total++; if (q_pair !== 8'h14) begin bad++; $display("FAIL switch_k1 got=%h want=%h", q_pair, 8'h14); end
    mode = 2'd0;
    tick();
    total++; if (q_pair !== 8'h18) begin bad++; $display("FAIL switch_k2 got=%h want=%h", q_pair, 8'h18); end
    tick();
    total++; if (q_pair !== 8'h97) begin bad++; $display("FAIL switch_k3 got=%h want=%h", q_pair, 8'h97); end
    tick();
    total++; if (q_pair !== 8'hF3) begin bad++; $display("FAIL switch_idle got=%h want=%h", q_pair, 8'hF3); end
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL switch_hold got=%b want=0", din_ready); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL switch_underrun got=%b want=0", underrun); end
  endtask

  task automatic test_reset_midword();
    mode = 2'd1;
    repeat (4) tick();
    total++; if (q_pair !== 8'h6C) begin bad++; $display("FAIL mid_k0 got=%h want=%h", q_pair, 8'h6C); end
    din = words[5]; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    total++; if (q_pair !== 8'h0A) begin bad++; $display("FAIL mid_k1 got=%h want=%h", q_pair, 8'h0A); end
    tick();
    total++; if (q_pair !== 8'h0C) begin bad++; $display("FAIL mid_k2 got=%h want=%h", q_pair, 8'h0C); end
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%b want=0", din_ready); end
    reset = 1'b1;
    tick();
    total++; if (q_pair !== 8'hF3) begin bad++; $display("FAIL midrst_qpair got=%h want=%h", q_pair, 8'hF3); end
    total++; if (underrun_count !== 8'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", underrun_count); end
    reset = 1'b0;
    #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL midrst_empty got=%b want=1", din_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (q_pair !== 8'hF3) begin bad++; $display("FAIL midrst_idle cyc=%0d got=%h want=%h", i, q_pair, 8'hF3); end
    end
    tick();
    total++; if (q_pair !== 8'hF3) begin bad++; $display("FAIL midrst_nopartial got=%h want=%h", q_pair, 8'hF3); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL midrst_underrun got=%b want=1", underrun); end
    total++; if (underrun_count !== 8'd1) begin bad++; $display("FAIL midrst_count1 got=%0d want=1", underrun_count); end
  endtask

  initial begin
    words[0] = {8'hF0, 8'h0F, 8'h3C, 8'hA5};
    words[1] = {8'h12, 8'h34, 8'h56, 8'h78};
    words[2] = {8'hFF, 8'h00, 8'hC3, 8'h96};
    words[3] = {8'h81, 8'h55, 8'h99, 8'hC3};
    words[4] = {8'h01, 8'h02, 8'h04, 8'h08};
    words[5] = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    test_reset();
    test_stream();
    test_underrun();
    test_train();
    test_mode_switch();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
